// File: rtl/axi_lite_rom_rd_if.sv
// AXI4-Lite slave front-end for one port of a read-only ROM: AR/R drive the ROM
// enable/address strobes, and every write completes with SLVERR.
module axi_lite_rom_rd_if #(
    parameter int AXI_AW    = 8,
    parameter int ROM_AW    = 3,
    parameter int ROM_DEPTH = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AXI_AW-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [AXI_AW-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);

    typedef enum logic [1:0] {RD_IDLE, RD_EN, RD_RESP} rd_state_t;
    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    rd_state_t         rd_state, rd_next;
    wr_state_t         wr_state, wr_next;
    logic [ROM_AW-1:0] rd_addr;
    logic              rd_err;
    logic              ar_fire;
    logic              ar_err;
    logic              aw_got, w_got, aw_got_next, w_got_next;
    logic              aw_done, w_done;

    // Write address/data payloads are deliberately discarded.
    logic unused_wr_payload;
    assign unused_wr_payload = ^{s_awaddr, s_wdata};

    assign ar_fire = (rd_state == RD_IDLE) && s_arvalid;
    assign ar_err  = (s_araddr >= AXI_AW'(ROM_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
            aw_got   <= aw_got_next;
            w_got    <= w_got_next;
        end
    end

    // Captured read request; only consumed while the read FSM is past RD_IDLE.
    always_ff @(posedge clk) begin
        if (ar_fire) begin
            rd_addr <= s_araddr[ROM_AW-1:0];
            rd_err  <= ar_err;
        end
    end

    always_comb begin
        rd_next   = rd_state;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = RESP_OKAY;
        rom_en    = 1'b0;
        rom_addr  = '0;
        case (rd_state)
            RD_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid)
                    rd_next = ar_err ? RD_RESP : RD_EN;
            end
            RD_EN: begin
                rom_en   = 1'b1;
                rom_addr = rd_addr;
                rd_next  = RD_RESP;
            end
            RD_RESP: begin
                // ROM output is held because its enable stays low here.
                s_rvalid = 1'b1;
                s_rdata  = rd_err ? '0 : rom_dout;
                s_rresp  = rd_err ? RESP_SLVERR : RESP_OKAY;
                if (s_rready)
                    rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_next     = wr_state;
        aw_got_next = aw_got;
        w_got_next  = w_got;
        aw_done     = 1'b0;
        w_done      = 1'b0;
        s_awready   = 1'b0;
        s_wready    = 1'b0;
        s_bvalid    = 1'b0;
        s_bresp     = RESP_OKAY;
        case (wr_state)
            WR_IDLE: begin
                s_awready = ~aw_got;
                s_wready  = ~w_got;
                aw_done   = aw_got | s_awvalid;
                w_done    = w_got | s_wvalid;
                if (aw_done && w_done) begin
                    wr_next     = WR_RESP;
                    aw_got_next = 1'b0;
                    w_got_next  = 1'b0;
                end else begin
                    aw_got_next = aw_done;
                    w_got_next  = w_done;
                end
            end
            WR_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = RESP_SLVERR;
                if (s_bready)
                    wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_rom_rd_if.sv
// Bench for axi_lite_rom_rd_if: directed and randomized AXI-Lite reads/writes
// against a ROM model and a transaction-level expectation of each response.
module tb_axi_lite_rom_rd_if;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_araddr;
    logic       s_arvalid;
    logic       s_arready;
    logic [7:0] s_rdata;
    logic [1:0] s_rresp;
    logic       s_rvalid;
    logic       s_rready;
    logic [7:0] s_awaddr;
    logic       s_awvalid;
    logic       s_awready;
    logic [7:0] s_wdata;
    logic       s_wvalid;
    logic       s_wready;
    logic [1:0] s_bresp;
    logic       s_bvalid;
    logic       s_bready;
    logic       rom_en;
    logic [2:0] rom_addr;
    logic [7:0] rom_dout = 8'h00;

    logic [7:0] mem [8];
    int         errors = 0;
    int         checks = 0;
    int         en_cnt = 0;
    logic [2:0] last_rom_addr = 3'd0;

    axi_lite_rom_rd_if #(.AXI_AW(8), .ROM_AW(3), .ROM_DEPTH(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;

    // Registered ROM: output only changes on an enabled clock.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_dout <= mem[rom_addr];
            en_cnt = en_cnt + 1;
            last_rom_addr = rom_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete read; hold = cycles rready stays low after rvalid rises.
    task automatic do_read(input logic [7:0] addr, input int hold);
        int         lat;
        int         en0;
        logic       err;
        logic [7:0] exp_data;
        err      = (addr >= 8'd8);
        exp_data = err ? 8'h00 : mem[addr[2:0]];
        en0      = en_cnt;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        s_rready  = 1'b0;
        check("arready_idle", 32'(s_arready), 32'd1);
        @(negedge clk);
        s_arvalid = 1'b0;
        s_araddr  = 8'($urandom);
        lat = 1;
        while (!s_rvalid && lat < 6) begin
            check("arready_busy", 32'(s_arready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("rd_latency", 32'(lat), err ? 32'd1 : 32'd2);
        for (int i = 0; i < hold; i++) begin
            check("rvalid_hold", 32'(s_rvalid), 32'd1);
            check("rdata_hold", 32'(s_rdata), 32'(exp_data));
            @(negedge clk);
        end
        check("rvalid", 32'(s_rvalid), 32'd1);
        check("rdata", 32'(s_rdata), 32'(exp_data));
        check("rresp", 32'(s_rresp), err ? 32'd2 : 32'd0);
        check("arready_in_resp", 32'(s_arready), 32'd0);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        check("rvalid_done", 32'(s_rvalid), 32'd0);
        check("arready_back", 32'(s_arready), 32'd1);
        check("rom_en_pulses", 32'(en_cnt - en0), err ? 32'd0 : 32'd1);
        if (!err)
            check("rom_addr", 32'(last_rom_addr), 32'(addr[2:0]));
    endtask

    // One write with AW issued at cycle ad and W at cycle wd.
    task automatic do_write(input int ad, input int wd, input int bhold);
        int mx;
        mx = (ad > wd) ? ad : wd;
        for (int t = 0; t <= mx; t++) begin
            s_awvalid = (t == ad);
            s_wvalid  = (t == wd);
            s_awaddr  = 8'($urandom);
            s_wdata   = 8'($urandom);
            check("awready_pre", 32'(s_awready), (t <= ad) ? 32'd1 : 32'd0);
            check("wready_pre", 32'(s_wready), (t <= wd) ? 32'd1 : 32'd0);
            check("bvalid_early", 32'(s_bvalid), 32'd0);
            @(negedge clk);
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check("bvalid", 32'(s_bvalid), 32'd1);
        check("bresp", 32'(s_bresp), 32'd2);
        check("awready_resp", 32'(s_awready), 32'd0);
        check("wready_resp", 32'(s_wready), 32'd0);
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(s_bvalid), 32'd1);
        end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        check("bvalid_done", 32'(s_bvalid), 32'd0);
        check("awready_back", 32'(s_awready), 32'd1);
        check("wready_back", 32'(s_wready), 32'd1);
    endtask

    initial begin
        int en0;
        for (int i = 0; i < 8; i++) mem[i] = 8'(i);
        rst_n = 1'b0;
        s_araddr = 8'h00; s_arvalid = 1'b0; s_rready = 1'b0;
        s_awaddr = 8'h00; s_awvalid = 1'b0; s_wdata = 8'h00; s_wvalid = 1'b0;
        s_bready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rom_en", 32'(rom_en), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rdata", 32'(s_rdata), 32'd0);
        check("rst_rresp", 32'(s_rresp), 32'd0);
        check("rst_bresp", 32'(s_bresp), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd1);
        check("rst_awready", 32'(s_awready), 32'd1);
        check("rst_wready", 32'(s_wready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single valid read, full sweep, error read, backpressured read
        do_read(8'd5, 0);
        en0 = en_cnt;
        for (int i = 0; i < 8; i++) do_read(8'(i), 0);
        check("sweep_pulses", 32'(en_cnt - en0), 32'd8);
        do_read(8'h09, 0);
        do_read(8'd3, 5);

        // Writes: AW first then W, same cycle, W first; concurrent read
        fork
            do_read(8'd2, 0);
            do_write(0, 3, 0);
        join
        do_write(0, 0, 2);
        do_write(2, 0, 0);

        // Reset while a response is pending
        s_araddr = 8'd4; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_rvalid", 32'(s_rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rvalid", 32'(s_rvalid), 32'd0);
        check("async_rst_rdata", 32'(s_rdata), 32'd0);
        check("async_rst_arready", 32'(s_arready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_rvalid", 32'(s_rvalid), 32'd0);
            check("post_rst_arready", 32'(s_arready), 32'd1);
        end

        // Randomized traffic against fresh ROM contents
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 4) == 0)
                do_read(8'($urandom), int'($urandom_range(0, 3)));
            else
                do_read(8'($urandom_range(0, 11)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0)
                do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_rom_rd_if.md
Name: axi_lite_rom_rd_if

Overview:
AXI4-Lite slave front-end for one port of the 8x8 mbank dual-port ROM. It converts AR/R transactions into the ROM's enable/address strobes and returns the ROM's registered read data on the R channel. Because the ROM is read-only, the block accepts and completes every write transaction with an error response. One instance serves each ROM port (A and B).

Parameters:
AXI_AW, 8, AXI address width (word-addressed: one address = one ROM entry)
ROM_AW, 3, ROM address width
ROM_DEPTH, 8, number of valid ROM entries; must be <= 2**ROM_AW
DATA_W, 8, data width of the ROM and of RDATA/WDATA

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
s_araddr  in  AXI_AW  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DATA_W  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_awaddr  in  AXI_AW  write address (ignored)
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DATA_W  write data (ignored)
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
rom_en  out  1  to ROM ena/enb
rom_addr  out  ROM_AW  to ROM addra/addrb
rom_dout  in  DATA_W  from ROM douta/doutb (1-cycle registered)

Behaviour:
- Reset (async, rst_n=0): read FSM -> RD_IDLE, write FSM -> WR_IDLE, aw_got=w_got=0. Immediately: s_rvalid=0, s_bvalid=0, rom_en=0, rom_addr=0, s_rresp=0, s_bresp=0, s_rdata=0. s_arready=s_awready=s_wready=1. Reset mid-transaction abandons it; no response is issued afterwards.
- Read FSM states: RD_IDLE, RD_EN, RD_RESP.
- RD_IDLE: s_arready=1. On arvalid&arready, the FSM registers the address and err = (s_araddr >= ROM_DEPTH).
  - err=0 -> RD_EN.
  - err=1 -> RD_RESP directly; the ROM is not accessed.
- RD_EN (exactly 1 cycle): rom_en=1, rom_addr = captured address[ROM_AW-1:0], s_arready=0. Next state RD_RESP.
- RD_RESP: s_rvalid=1, s_arready=0, rom_en=0.
  - s_rdata = err ? 0 : rom_dout. The ROM holds its output because its enable is low.
  - s_rresp = err ? 2'b10 (SLVERR) : 2'b00 (OKAY).
  - s_rdata and s_rresp stay stable while s_rvalid=1 and s_rready=0.
  - On s_rready=1 -> RD_IDLE.
- Read latency: AR handshake at edge E0 -> s_rvalid high after E1 (valid read) or after E0 (error read). Minimum 3 cycles per valid read, 2 per error read. At most one read outstanding. s_rvalid never depends combinationally on s_rready.
- rom_en is high only in RD_EN: exactly one pulse per valid read, none for error reads.
- Write FSM states: WR_IDLE, WR_RESP.
  - WR_IDLE: s_awready = ~aw_got, s_wready = ~w_got. Each handshake sets its flag. AW and W may arrive in either order or in the same cycle.
  - When both handshakes are complete (flags, or same-cycle handshakes) -> WR_RESP on the next edge; flags clear.
  - WR_RESP: s_bvalid=1, s_bresp=2'b10, s_awready=s_wready=0. On s_bready -> WR_IDLE.
  - The write path never touches the ROM.
- Read and write FSMs are fully independent; simultaneous read and write proceed concurrently.
- Address width rule: only addresses < ROM_DEPTH are valid; the upper bits of a valid address are zero by definition.

Test Plan:
- Reset, then read araddr=5 with rready=1 -> one rom_en pulse with rom_addr=5; rvalid one cycle later; rdata=8'h05, rresp=OKAY.
- Read all addresses 0..7 back-to-back with rready=1 -> rdata 00..07 in order, arready low between, exactly 8 rom_en pulses.
- Read araddr=8'h09 -> no rom_en; rvalid the cycle after the handshake; rdata=0, rresp=2'b10.
- Read addr 3 with rready held 0 for 5 cycles -> rvalid=1, rdata=03 stable throughout; then rready=1 -> arready=1 the next cycle.
- Write with AW first, W 3 cycles later, then repeat with both in the same cycle -> one bvalid per write, bresp=2'b10; a concurrent read of addr 2 returns 02 unaffected.
- Drop rst_n while in RD_RESP with rready=0 -> rvalid=0 immediately; after release arready=1 and no stale response appears.
